// File: rtl/up_down.sv
// Free-running WIDTH-bit up/down counter with Gray-coded view, terminal flags
// and a one-cycle pulse marking the cycle that shows a wrapped value.
module up_down #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             updown,
    output logic [WIDTH-1:0] bin_count,
    output logic [WIDTH-1:0] gray_count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = '0;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin_next_c;
    logic             wrap_next_c;

    // Terminal flags and Gray view decode straight from the count register.
    assign at_max     = (bin_count == CNT_MAX);
    assign at_min     = (bin_count == CNT_MIN);
    assign gray_count = bin_count ^ (bin_count >> 1);

    // A wrap happens when stepping past the terminal value in the chosen direction.
    always_comb begin
        bin_next_c  = bin_count;
        wrap_next_c = 1'b0;
        if (updown) begin
            bin_next_c  = bin_count + CNT_ONE;
            wrap_next_c = at_max;
        end else begin
            bin_next_c  = bin_count - CNT_ONE;
            wrap_next_c = at_min;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_count <= '0;
            wrap      <= 1'b0;
        end else begin
            bin_count <= bin_next_c;
            wrap      <= wrap_next_c;
        end
    end

endmodule

// File: tb/tb_up_down.sv
// Directed bench for up_down (WIDTH = 3): reset, counting, reversals,
// asynchronous reset mid-count and a fixed mixed-direction sequence.
module tb_up_down;

    localparam int unsigned WIDTH = 3;

    logic             clk;
    logic             reset;
    logic             updown;
    logic [WIDTH-1:0] bin_count;
    logic [WIDTH-1:0] gray_count;
    logic             at_max;
    logic             at_min;
    logic             wrap;

    int n_checks;
    int n_errors;

    up_down #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .updown     (updown),
        .bin_count  (bin_count),
        .gray_count (gray_count),
        .at_max     (at_max),
        .at_min     (at_min),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Full output check against an expected count and wrap value.
    task automatic check_state(input string tag, input logic [2:0] exp_bin, input logic exp_wrap);
        logic [2:0] exp_gray;
        exp_gray = exp_bin ^ (exp_bin >> 1);
        check({tag, ".bin"},  32'(bin_count),  32'(exp_bin));
        check({tag, ".gray"}, 32'(gray_count), 32'(exp_gray));
        check({tag, ".max"},  32'(at_max),     32'(exp_bin == 3'd7));
        check({tag, ".min"},  32'(at_min),     32'(exp_bin == 3'd0));
        check({tag, ".wrap"}, 32'(wrap),       32'(exp_wrap));
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, then release it away from any edge.
    task automatic do_reset(input logic dir);
        @(negedge clk);
        reset  = 1'b0;
        updown = dir;
        #1;
        check_state("rst", 3'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [2:0]  up_bin  [8];
    logic [2:0]  up_gray [8];
    logic [19:0] pattern;
    logic [2:0]  m_bin;
    logic        m_wrap;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        updown   = 1'b1;
        up_bin   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        up_gray  = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
        pattern  = 20'b1011_0110_0011_1000_0100;

        // 1: reset, then count up through a wrap
        #12;
        check_state("t1.reset", 3'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1.bin",  32'(bin_count),  32'(up_bin[i]));
            check("t1.gray", 32'(gray_count), 32'(up_gray[i]));
            check("t1.wrap", 32'(wrap),       32'(i == 7));
            check("t1.max",  32'(at_max),     32'(i == 6));
        end

        // 2: count down from reset
        do_reset(1'b0);
        tick(); check_state("t2.s7", 3'd7, 1'b1);
        tick(); check_state("t2.s6", 3'd6, 1'b0);
        tick(); check_state("t2.s5", 3'd5, 1'b0);

        // 3: reversal mid-range
        do_reset(1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_state("t3.up", 3'(i), 1'b0);
        end
        updown = 1'b0;
        tick(); check_state("t3.s4", 3'd4, 1'b0);
        tick(); check_state("t3.s3", 3'd3, 1'b0);
        updown = 1'b1;
        tick(); check_state("t3.s4b", 3'd4, 1'b0);

        // 4: reversal at terminal values
        tick(); tick(); tick();
        check_state("t4.at7", 3'd7, 1'b0);
        updown = 1'b0;
        tick(); check_state("t4.s6", 3'd6, 1'b0);
        for (int i = 5; i >= 0; i--) tick();
        check_state("t4.at0", 3'd0, 1'b0);
        updown = 1'b1;
        tick(); check_state("t4.s1", 3'd1, 1'b0);

        // 5: asynchronous reset mid-count
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) tick();
        check_state("t5.at5", 3'd5, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_state("t5.async", 3'd0, 1'b0);
        tick();
        check_state("t5.held", 3'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick(); check_state("t5.first", 3'd1, 1'b0);

        // 5b: reset clears a live wrap pulse without a clock
        for (int i = 0; i < 7; i++) tick();
        check_state("t5.wrap", 3'd0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_state("t5.wclr", 3'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // 6: mixed directions, new direction every 2 cycles, reference model
        do_reset(1'b0);
        m_bin = 3'd0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) updown = pattern[i/2];
            m_wrap = updown ? (m_bin == 3'd7) : (m_bin == 3'd0);
            m_bin  = updown ? m_bin + 3'd1 : m_bin - 3'd1;
            tick();
            check_state("t6", m_bin, m_wrap);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/up_down.md
Name: up_down

Overview:
Free-running binary up/down counter, WIDTH bits (default 3). It advances by one on every rising clock edge, with the direction selected by updown each cycle. It wraps modulo 2^WIDTH. It also provides Gray-coded count, terminal-value flags and a one-cycle wrap pulse for downstream sequencing and status logic.

Parameters:
WIDTH, 3, counter width in bits; legal range 2..16.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
updown  input  1  count direction: 1 = count up, 0 = count down; sampled at each rising clk edge.
bin_count  output  WIDTH  registered binary count value.
gray_count  output  WIDTH  Gray code of bin_count: bin_count XOR (bin_count >> 1); combinational from the register.
at_max  output  1  combinational; 1 when bin_count == 2^WIDTH-1.
at_min  output  1  combinational; 1 when bin_count == 0.
wrap  output  1  registered pulse; 1 for exactly one cycle after an edge on which the count wrapped.

Behaviour:
- Reset (reset == 0, asynchronous assert):
  - bin_count = 0 and wrap = 0 immediately, with no clock required.
  - Therefore gray_count = 0, at_min = 1, at_max = 0.
  - Held while reset is low.
- Reset release:
  - Synchronous in effect; the first count update occurs on the first rising clk edge with reset == 1.
- Each rising clk edge with reset == 1:
  - updown == 1: bin_count <= bin_count + 1, modulo 2^WIDTH.
  - updown == 0: bin_count <= bin_count - 1, modulo 2^WIDTH.
- No hold/enable: the count changes on every clock edge while out of reset.
- Latency: a change on updown affects the count at the next rising edge. bin_count reflects the direction sampled at that edge.
- Wrap-around:
  - Up from 2^WIDTH-1 goes to 0.
  - Down from 0 goes to 2^WIDTH-1.
  - On that same edge wrap <= 1. On every other edge wrap <= 0.
  - wrap is therefore high during the cycle in which bin_count shows the wrapped value.
- Direction change at a terminal value:
  - At 7 with updown == 0, the next value is 6 and wrap stays 0.
  - At 0 with updown == 1, the next value is 1 and wrap stays 0.
- gray_count, at_max and at_min:
  - Pure functions of bin_count; they change only when bin_count changes, glitch-free relative to the register.
- Reset mid-count:
  - Asserting reset at any time forces bin_count to 0 and wrap to 0 asynchronously, overriding any pending update.
- X on updown:
  - Not supported; the bench must drive 0/1 only.
- Defaults:
  - No internal state other than bin_count and wrap.
  - Outputs are never X after the first reset assertion.

Test Plan:
1. Reset, then count up: reset = 0 for 10 ns, release, hold updown = 1 for 8 edges.
   - Required: bin_count 0 -> 1 -> 2 -> ... -> 7 -> 0.
   - wrap = 1 only in the cycle showing the 0 after 7.
   - gray_count sequence 0, 1, 3, 2, 6, 7, 5, 4, 0.
2. Count down from reset: release reset with updown = 0.
   - Required: bin_count 0 -> 7 (wrap = 1) -> 6 -> 5.
   - at_max = 1 while bin_count = 7; at_min = 1 only while bin_count = 0.
3. Direction reversal: count up to 5, set updown = 0 before the next edge.
   - Required: 5 -> 4 -> 3.
   - Set updown = 1 at 3: 3 -> 4.
   - No wrap pulses.
4. Reversal at terminal values:
   - At 7 set updown = 0: next value 6, wrap = 0.
   - At 0 set updown = 1: next value 1, wrap = 0.
5. Asynchronous reset mid-count: at bin_count = 5, drive reset = 0 between clock edges.
   - Required: bin_count = 0 and wrap = 0 immediately, before the next edge, and held while reset is low.
   - After release with updown = 1, the first edge gives 1.
6. Randomised direction: after reset, toggle updown to random 0/1 every 2 cycles for 40 cycles.
   - Required: every edge, bin_count equals a reference model of previous ±1 mod 8.
   - wrap matches the reference model's wrap events.
